// File: rtl/bnn_loader_pkg.sv
// Shared encoding and widths for the BNN parameter loader and its serializer.
package bnn_loader_pkg;

    localparam int PHASE_CYCLES = 2;
    localparam int NIBBLE_W     = 4;
    localparam int BYTE_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CFG_WAIT  = 3'd1,
        S_CFG_SHIFT = 3'd2,
        S_CFG_CHK   = 3'd3,
        S_RUN       = 3'd4,
        S_X_LO      = 3'd5,
        S_X_HI      = 3'd6
    } state_t;

endpackage

// File: rtl/bnn_serializer.sv
// Shifts a byte out as 8 single bits or 2 nibbles; each step is one bnn_clk
// period (low phase with new data, high phase with data held). All outputs registered.
module bnn_serializer
    import bnn_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    input  logic                load,
    input  logic                nib_mode,
    input  logic [BYTE_W-1:0]   load_data,
    output logic                step_end,
    output logic                done,
    output logic                bnn_clk,
    output logic                bnn_param,
    output logic                bnn_x_bank_hi,
    output logic [NIBBLE_W-1:0] bnn_x
);

    localparam int PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int CNT_W = 3;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(PHASE_CYCLES / 2);

    logic [BYTE_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic                active_q, active_d;
    logic                nib_q, nib_d;
    logic                clk_q, clk_d;
    logic                param_q, param_d;
    logic                bank_q, bank_d;
    logic [NIBBLE_W-1:0] x_q, x_d;

    assign step_end      = active_q && (ph_q == PH_LAST);
    assign done          = step_end && (cnt_q == '0);
    assign bnn_clk       = clk_q;
    assign bnn_param     = param_q;
    assign bnn_x_bank_hi = bank_q;
    assign bnn_x         = x_q;

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        active_d = active_q;
        nib_d    = nib_q;
        clk_d    = clk_q;
        param_d  = param_q;
        bank_d   = bank_q;
        x_d      = x_q;
        if (abort) begin
            active_d = 1'b0;
            ph_d     = '0;
            clk_d    = 1'b0;
        end else if (load) begin
            sh_d     = load_data;
            nib_d    = nib_mode;
            active_d = 1'b1;
            ph_d     = '0;
            clk_d    = 1'b0;
            cnt_d    = nib_mode ? CNT_W'(BYTE_W / NIBBLE_W - 1) : CNT_W'(BYTE_W - 1);
            if (nib_mode) begin
                bank_d = 1'b0;
                x_d    = load_data[NIBBLE_W-1:0];
            end else begin
                param_d = load_data[0];
            end
        end else if (active_q) begin
            if (step_end) begin
                ph_d  = '0;
                clk_d = 1'b0;
                if (cnt_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (nib_q) begin
                        sh_d   = sh_q >> NIBBLE_W;
                        bank_d = 1'b1;
                        x_d    = sh_q[2*NIBBLE_W-1:NIBBLE_W];
                    end else begin
                        sh_d    = sh_q >> 1;
                        param_d = sh_q[1];
                    end
                end
            end else begin
                ph_d  = ph_q + PH_W'(1);
                clk_d = (ph_d >= PH_HALF);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            ph_q     <= '0;
            active_q <= 1'b0;
            nib_q    <= 1'b0;
            clk_q    <= 1'b0;
            param_q  <= 1'b0;
            bank_q   <= 1'b0;
            x_q      <= '0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            active_q <= active_d;
            nib_q    <= nib_d;
            clk_q    <= clk_d;
            param_q  <= param_d;
            bank_q   <= bank_d;
            x_q      <= x_d;
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// BNN parameter loader: configures the BNN parameter chain, then streams input bytes as nibbles.
// Defining BNN_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the sticky cfg_err flag.
module bnn_param_loader
    import bnn_loader_pkg::*;
#(
    parameter int PARAM_BYTES = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [BYTE_W-1:0]   cfg_data,
    output logic                cfg_ready,
    input  logic                x_valid,
    input  logic [BYTE_W-1:0]   x_data,
    output logic                x_ready,
    output logic                bnn_clk,
    output logic                bnn_setup,
    output logic                bnn_param,
    output logic                bnn_x_bank_hi,
    output logic [NIBBLE_W-1:0] bnn_x,
    output logic                loaded,
    output logic                cfg_err,
    output state_t              dbg_state
);

    localparam int CNT_W = $clog2(PARAM_BYTES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              setup_q, setup_d;
    logic              loaded_q, loaded_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              x_ready_q, x_ready_d;
`ifdef BNN_LOADER_CHECKSUM_EN
    logic              err_q, err_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic              ser_abort, ser_load, ser_nib, ser_step_end, ser_done;
    logic [BYTE_W-1:0] ser_data;
    logic              start_ok, cfg_fire, x_fire;

    // Valid/ready: a byte moves on the clk edge where both are high; cfg_start
    // masks both readies so a restart always beats a pending offer.
    assign cfg_ready = cfg_ready_q & ~cfg_start;
    assign x_ready   = x_ready_q & ~cfg_start;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign x_fire    = x_valid & x_ready;
    assign start_ok  = cfg_start && (state_q != S_X_LO) && (state_q != S_X_HI);

    assign bnn_setup = setup_q;
    assign loaded    = loaded_q;
    assign dbg_state = state_q;
`ifdef BNN_LOADER_CHECKSUM_EN
    assign cfg_err   = err_q;
`else
    assign cfg_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ser_abort  = 1'b0;
        ser_load   = 1'b0;
        ser_nib    = 1'b0;
        ser_data   = cfg_data;
`ifdef BNN_LOADER_CHECKSUM_EN
        err_d      = err_q;
        csum_d     = csum_q;
`endif
        if (start_ok) begin
            state_d    = S_CFG_WAIT;
            byte_cnt_d = '0;
            ser_abort  = 1'b1;
`ifdef BNN_LOADER_CHECKSUM_EN
            err_d      = 1'b0;
            csum_d     = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_CFG_WAIT: begin
                    if (cfg_fire) begin
                        ser_load = 1'b1;
                        state_d  = S_CFG_SHIFT;
`ifdef BNN_LOADER_CHECKSUM_EN
                        csum_d   = csum_q ^ cfg_data;
`endif
                    end
                end
                S_CFG_SHIFT: begin
                    if (ser_done) begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_d == CNT_W'(PARAM_BYTES)) begin
`ifdef BNN_LOADER_CHECKSUM_EN
                            state_d = S_CFG_CHK;
`else
                            state_d = S_RUN;
`endif
                        end else begin
                            state_d = S_CFG_WAIT;
                        end
                    end
                end
`ifdef BNN_LOADER_CHECKSUM_EN
                S_CFG_CHK: begin
                    if (cfg_fire) begin
                        err_d   = (cfg_data != csum_q);
                        state_d = S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    if (x_fire) begin
                        ser_load = 1'b1;
                        ser_nib  = 1'b1;
                        ser_data = x_data;
                        state_d  = S_X_LO;
                    end
                end
                S_X_LO: if (ser_step_end) state_d = S_X_HI;
                S_X_HI: if (ser_done) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
        setup_d     = (state_d == S_CFG_WAIT) || (state_d == S_CFG_SHIFT) || (state_d == S_CFG_CHK);
        cfg_ready_d = (state_d == S_CFG_WAIT) || (state_d == S_CFG_CHK);
        loaded_d    = (state_d == S_RUN) || (state_d == S_X_LO) || (state_d == S_X_HI);
        x_ready_d   = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            setup_q     <= 1'b0;
            loaded_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            x_ready_q   <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
            err_q       <= 1'b0;
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            setup_q     <= setup_d;
            loaded_q    <= loaded_d;
            cfg_ready_q <= cfg_ready_d;
            x_ready_q   <= x_ready_d;
`ifdef BNN_LOADER_CHECKSUM_EN
            err_q       <= err_d;
            csum_q      <= csum_d;
`endif
        end
    end

    bnn_serializer u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort         (ser_abort),
        .load          (ser_load),
        .nib_mode      (ser_nib),
        .load_data     (ser_data),
        .step_end      (ser_step_end),
        .done          (ser_done),
        .bnn_clk       (bnn_clk),
        .bnn_param     (bnn_param),
        .bnn_x_bank_hi (bnn_x_bank_hi),
        .bnn_x         (bnn_x)
    );

endmodule

// File: doc/bnn_param_loader.md
BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

Interface
REQ-001 SHALL have parameter: PARAM_BYTES, default 20, number of 8-bit bytes shifted into the downstream BNN parameter chain (min 1).
REQ-002 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: cfg_start  in  1  one-cycle pulse; begin (re)configuration.
REQ-005 SHALL have ports: cfg_valid / cfg_data  in  1 / 8  parameter byte offer; cfg_ready  out  1  byte accepted when valid&ready.
REQ-006 SHALL have ports: x_valid / x_data  in  1 / 8  inference input byte offer; x_ready  out  1.
REQ-007 SHALL have ports: bnn_clk  out  1  generated user clock to BNN core; bnn_setup  out  1; bnn_param  out  1; bnn_x_bank_hi  out  1; bnn_x  out  4.
REQ-008 SHALL have ports: loaded  out  1  chain fully configured; cfg_err  out  1  checksum mismatch, sticky.

Function
REQ-009 SHALL implement states IDLE, CFG_WAIT, CFG_SHIFT, CFG_CHK (macro only), RUN, X_LO, X_HI.
REQ-010 IDLE: setup=0, loaded=0, cfg_ready=x_ready=0; cfg_start -> CFG_WAIT, byte_cnt=0.
REQ-011 CFG_WAIT: bnn_setup=1, cfg_ready=1; handshake latches byte -> CFG_SHIFT.
REQ-012 Each bit/nibble SHALL occupy 2 cycles: phase A bnn_clk=0 with data updated, phase B bnn_clk=1 with data held; all BNN outputs registered.
REQ-013 CFG_SHIFT: 8 bits LSB-first on bnn_param, 16 cycles; then byte_cnt+1; if byte_cnt==PARAM_BYTES -> CFG_CHK (macro) else RUN; otherwise -> CFG_WAIT.
REQ-014 RUN: bnn_setup=0, loaded=1, x_ready = !cfg_start; handshake -> X_LO.
REQ-015 X_LO: bank_hi=0, bnn_x=x_data[3:0], 2 cycles -> X_HI: bank_hi=1, bnn_x=x_data[7:4], 2 cycles -> RUN; byte-to-byte throughput 5 cycles min.
REQ-016 cfg_start SHALL be honoured in IDLE, CFG_WAIT, CFG_SHIFT, RUN: -> CFG_WAIT, byte_cnt=0, loaded=0, cfg_err=0, bnn_clk forced 0; partial byte discarded.
REQ-017 cfg_start SHALL be ignored in X_LO/X_HI (nibble pair completes); cfg_start wins over x_valid in RUN.
REQ-018 cfg_valid outside CFG_WAIT/CFG_CHK and x_valid outside RUN SHALL be ignored (ready=0).
REQ-019 byte_cnt SHALL be $clog2(PARAM_BYTES+1) bits, never wraps.

Reset
REQ-020 rst_n low SHALL force IDLE, all outputs 0, byte_cnt=0, checksum=0, immediately (asynchronous).
REQ-021 Deassertion SHALL take effect at next clk edge; no config survives reset.

Configuration
REQ-022 Macro BNN_LOADER_CHECKSUM_EN defined: running XOR of all parameter bytes; CFG_CHK accepts one extra byte (cfg_ready=1, not shifted, bnn_setup=1), cfg_err=(byte!=XOR), -> RUN regardless.
REQ-023 Macro undefined: no CFG_CHK, no checksum register, cfg_err tied 0, last byte goes directly to RUN.

Structure
REQ-024 Shared package bnn_loader_pkg SHALL hold state encoding typedef, PHASE_CYCLES=2, NIBBLE_W=4, BYTE_W=8.
REQ-025 Sub-module bnn_serializer SHALL hold the byte shift register, bit counter and bnn_clk phase generator; FSM/handshake in top.

Verification
REQ-026 PARAM_BYTES=2, cfg_start, bytes 0xA5,0x3C -> bnn_param sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 bnn_clk rises; loaded=1, setup=0 afterward.
REQ-027 In RUN send x=0x7E -> bank_hi=0,bnn_x=0xE at first rise, then bank_hi=1,bnn_x=0x7 at second rise; x_ready low 4 cycles.
REQ-028 cfg_start after 3 bits of byte 0 -> exactly 16 further bnn_clk rises for 2 new bytes, loaded=0 until done.
REQ-029 CHECKSUM_EN, bytes 0xA5,0x3C then 0x99 -> cfg_err=0; then 0x98 on reload -> cfg_err=1 until next cfg_start.
REQ-030 rst_n low mid-X_HI -> all outputs 0 same cycle, x_ready=0 until reconfigured.
